// File: rtl/spr_dma_ctl_if.sv
// Sprite DMA bus bundle: CPU-side request signals and DMA bus outputs.
// master drives the CPU/bus side, slave is the DMA controller.
interface spr_dma_ctl_if;
  logic        cpu_cyc_in;
  logic [15:0] cpu_a_in;
  logic [7:0]  cpu_d_in;
  logic        cpu_r_nw_in;
  logic [7:0]  mem_d_in;
  logic        cpu_rdy_out;
  logic        dma_active_out;
  logic [15:0] mem_a_out;
  logic        mem_r_nw_out;
  logic [7:0]  mem_d_out;
  logic        dma_done_out;

  modport master (
    output cpu_cyc_in, cpu_a_in, cpu_d_in,
    output cpu_r_nw_in, mem_d_in,
    input  cpu_rdy_out, dma_active_out,
    input  mem_a_out, mem_r_nw_out,
    input  mem_d_out, dma_done_out
  );

  modport slave (
    input  cpu_cyc_in, cpu_a_in, cpu_d_in,
    input  cpu_r_nw_in, mem_d_in,
    output cpu_rdy_out, dma_active_out,
    output mem_a_out, mem_r_nw_out,
    output mem_d_out, dma_done_out
  );
endinterface

// File: rtl/spr_dma_ctl.sv
// Sprite DMA controller: $4014 write copies one CPU page to $2004.
// SPR_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN dummy read.
module spr_dma_ctl (
  input logic          clk_in,
  input logic          rst_n_in,
  spr_dma_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        done_d;
  logic        go_align;
  logic        wr_4014;
  logic [15:0] a_d;
  logic [7:0]  dout_d;

  assign wr_4014 = (bus.cpu_a_in == 16'h4014)
                 && !bus.cpu_r_nw_in;

`ifdef SPR_DMA_ODD_ALIGN_EN
  // 1 means the CPU is on an odd cycle
  logic parity_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      parity_q <= 1'b0;
    else if (bus.cpu_cyc_in)
      parity_q <= ~parity_q;
  end

  assign go_align = parity_q;
`else
  assign go_align = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (bus.cpu_cyc_in) begin
      unique case (1'b1)
        (state_q == S_IDLE): begin
          if (wr_4014) begin
            state_d = S_HALT;
            page_d  = bus.cpu_d_in;
            cnt_d   = 8'h00;
          end
        end
        (state_q == S_HALT):
          state_d = go_align ? S_ALIGN : S_READ;
        (state_q == S_ALIGN):
          state_d = S_READ;
        (state_q == S_READ): begin
          data_d  = bus.mem_d_in;
          state_d = S_WRITE;
        end
        (state_q == S_WRITE): begin
          if (cnt_q == 8'hFF) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_READ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs are registered from the next-state view
  always_comb begin
    a_d    = 16'h0000;
    dout_d = 8'h00;
    unique case (1'b1)
      (state_d == S_HALT),
      (state_d == S_ALIGN): a_d = 16'h4014;
      (state_d == S_READ):  a_d = {page_d, cnt_d};
      (state_d == S_WRITE): begin
        a_d    = 16'h2004;
        dout_d = data_d;
      end
      default: a_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q            <= S_IDLE;
      page_q             <= 8'h00;
      cnt_q              <= 8'h00;
      data_q             <= 8'h00;
      bus.cpu_rdy_out    <= 1'b1;
      bus.dma_active_out <= 1'b0;
      bus.mem_a_out      <= 16'h0000;
      bus.mem_r_nw_out   <= 1'b1;
      bus.mem_d_out      <= 8'h00;
      bus.dma_done_out   <= 1'b0;
    end else begin
      state_q            <= state_d;
      page_q             <= page_d;
      cnt_q              <= cnt_d;
      data_q             <= data_d;
      bus.cpu_rdy_out    <= (state_d == S_IDLE);
      bus.dma_active_out <= (state_d != S_IDLE);
      bus.mem_a_out      <= a_d;
      bus.mem_r_nw_out   <= (state_d != S_WRITE);
      bus.mem_d_out      <= dout_d;
      bus.dma_done_out   <= done_d;
    end
  end

endmodule

// File: tb/tb_spr_dma_ctl.sv
// Directed bench for spr_dma_ctl: page copies, timing, pause,
// ignored retrigger, mid-transfer reset and page 0xFF.
module tb_spr_dma_ctl;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   ncyc = 0;

  spr_dma_ctl_if bus ();

  spr_dma_ctl dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  always #10 clk_in = ~clk_in;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a[15:8] == 8'h02)
      return a[7:0] ^ 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always_comb bus.mem_d_in = memf(bus.mem_a_out);

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // one CPU cycle commit: cyc pulse for one clk, bus restored after
  task automatic pulse();
    bus.cpu_cyc_in = 1'b1;
    tick();
    bus.cpu_cyc_in  = 1'b0;
    bus.cpu_a_in    = 16'h0000;
    bus.cpu_d_in    = 8'h00;
    bus.cpu_r_nw_in = 1'b1;
    if (rst_n_in) ncyc++;
  endtask

  task automatic run_dma(input logic [7:0] pg,
                         input int pause_at,
                         input int inject_at,
                         input int reset_at);
    int wr_idx = 0;
    int bad_d = 0;
    int bad_a = 0;
    int cycles = 0;
    int dones = 0;
    int exp_len = 513;
    int p_at = pause_at;
    bit aborted = 1'b0;
    logic [7:0] ix;

    bus.cpu_a_in    = 16'h4014;
    bus.cpu_d_in    = pg;
    bus.cpu_r_nw_in = 1'b0;
    pulse();
    chk("rdy_drop", {31'd0, bus.cpu_rdy_out}, 32'd0);
    chk("act_rise", {31'd0, bus.dma_active_out}, 32'd1);
`ifdef SPR_DMA_ODD_ALIGN_EN
    if (ncyc % 2 == 1) exp_len = 514;
`endif
    tick();

    for (int g = 0; g < 600; g++) begin
      ix = wr_idx[7:0];
      if (bus.dma_active_out && !bus.mem_r_nw_out) begin
        if (bus.mem_a_out != 16'h2004 ||
            bus.mem_d_out != memf({pg, ix}))
          bad_d++;
        wr_idx++;
      end else if (bus.dma_active_out &&
                   bus.mem_a_out != 16'h4014) begin
        if (bus.mem_a_out != {pg, ix}) bad_a++;
      end

      if (reset_at >= 0 && bus.dma_active_out &&
          bus.mem_a_out == {pg, 8'(reset_at)}) begin
        rst_n_in = 1'b0;
        tick();
        chk("rst_rdy", {31'd0, bus.cpu_rdy_out}, 32'd1);
        chk("rst_act", {31'd0, bus.dma_active_out}, 32'd0);
        chk("rst_addr", {16'd0, bus.mem_a_out}, 32'd0);
        chk("rst_done", {31'd0, bus.dma_done_out}, 32'd0);
        rst_n_in = 1'b1;
        ncyc = 0;
        tick();
        chk("rst_nodone", {31'd0, bus.dma_done_out}, 32'd0);
        aborted = 1'b1;
        break;
      end

      if (p_at >= 0 && p_at == wr_idx && bus.dma_active_out &&
          bus.mem_r_nw_out && bus.mem_a_out != 16'h4014) begin
        repeat (10) tick();
        chk("pause_addr", {16'd0, bus.mem_a_out},
            {16'd0, pg, 8'(p_at)});
        chk("pause_act", {31'd0, bus.dma_active_out}, 32'd1);
        p_at = -1;
      end

      if (inject_at >= 0 && !bus.mem_r_nw_out &&
          wr_idx - 1 == inject_at) begin
        bus.cpu_a_in    = 16'h4014;
        bus.cpu_d_in    = 8'h77;
        bus.cpu_r_nw_in = 1'b0;
        pulse();
        cycles++;
        chk("inject_addr", {16'd0, bus.mem_a_out},
            {16'd0, pg, 8'(inject_at + 1)});
      end else begin
        pulse();
        cycles++;
      end

      if (bus.dma_done_out) dones++;
      if (bus.cpu_rdy_out) begin
        chk("end_sync",
            {30'd0, bus.dma_done_out, bus.dma_active_out},
            32'd2);
        break;
      end
      tick();
    end

    if (!aborted) begin
      chk("length", cycles, exp_len);
      chk("wr_data_errs", bad_d, 0);
      chk("rd_addr_errs", bad_a, 0);
      chk("wr_count", wr_idx, 256);
      chk("done_pulses", dones, 1);
      tick();
      chk("done_fall", {31'd0, bus.dma_done_out}, 32'd0);
      chk("idle_addr", {16'd0, bus.mem_a_out}, 32'd0);
    end
  endtask

  initial begin
    bus.cpu_cyc_in  = 1'b0;
    bus.cpu_a_in    = 16'h0000;
    bus.cpu_d_in    = 8'h00;
    bus.cpu_r_nw_in = 1'b1;
    rst_n_in = 1'b0;
    repeat (3) tick();
    chk("rst_rdy0", {31'd0, bus.cpu_rdy_out}, 32'd1);
    chk("rst_act0", {31'd0, bus.dma_active_out}, 32'd0);
    chk("rst_a0", {16'd0, bus.mem_a_out}, 32'd0);
    chk("rst_rnw0", {31'd0, bus.mem_r_nw_out}, 32'd1);
    chk("rst_d0", {24'd0, bus.mem_d_out}, 32'd0);
    chk("rst_done0", {31'd0, bus.dma_done_out}, 32'd0);
    rst_n_in = 1'b1;
    ncyc = 0;
    tick();

    bus.cpu_a_in = 16'h4014;
    bus.cpu_r_nw_in = 1'b1;
    pulse();
    chk("read4014_rdy", {31'd0, bus.cpu_rdy_out}, 32'd1);
    chk("read4014_act", {31'd0, bus.dma_active_out}, 32'd0);
    tick();

    run_dma(8'h02, -1, -1, -1);
    pulse();
    tick();
    run_dma(8'h02, -1, -1, -1);
    run_dma(8'h11, 8'h30, 8'h40, -1);
    run_dma(8'hFF, -1, -1, -1);
    run_dma(8'h05, -1, -1, 8'h80);
    run_dma(8'h05, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spr_dma_ctl.md
# spr_dma_ctl

Sprite DMA controller for the NES core: decodes CPU writes to 0x4014, halts the CPU, and sequences 256 read/write pairs that copy CPU page {page,0x00..0xFF} into sprite RAM through the PPU 0x2004 register write path. It sits between the CPU core and the system bus mux. While DMA is active it owns the shared bus, and its address/data/r_nw outputs replace the CPU's.

## Interface
- No parameters.
- clk_in  input  1  50 MHz system clock.
- rst_n_in  input  1  reset, synchronous, active-low.
- cpu_cyc_in  input  1  one-clk_in pulse marking the last clk_in of each CPU cycle; all CPU-visible actions commit on this pulse.
- cpu_a_in  input  16  CPU address bus.
- cpu_d_in  input  8  CPU write data.
- cpu_r_nw_in  input  1  CPU read(1)/write(0).
- mem_d_in  input  8  bus read data (valid on the cpu_cyc_in pulse of a read cycle).
- cpu_rdy_out  output  1  CPU ready; low halts the CPU.
- dma_active_out  output  1  high while this block owns the bus; the bus mux selects the mem_* outputs.
- mem_a_out  output  16  DMA bus address.
- mem_r_nw_out  output  1  DMA read(1)/write(0).
- mem_d_out  output  8  DMA write data.
- dma_done_out  output  1  one-clk_in pulse on completion.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: on cpu_cyc_in with cpu_a_in=16'h4014 and cpu_r_nw_in=0, latch page=cpu_d_in, clear cnt[7:0], and go to HALT. cpu_rdy_out drops in the same clk_in edge.
- HALT: a single dummy CPU cycle that lets the CPU finish its write. dma_active_out=1, mem_r_nw_out=1, mem_a_out=cpu_a_in passthrough is not used, and mem_a_out holds 16'h4014. On cpu_cyc_in, go to ALIGN if alignment is required (see Configuration), else go to READ.
- ALIGN: one dummy read cycle with the same outputs as HALT. On cpu_cyc_in, go to READ.
- READ: mem_a_out={page,cnt}, mem_r_nw_out=1. On cpu_cyc_in, latch mem_d_in into the data register and go to WRITE.
- WRITE: mem_a_out=16'h2004, mem_r_nw_out=0, mem_d_out=data register. On cpu_cyc_in: if cnt=8'hFF, go to IDLE and pulse dma_done_out; otherwise cnt=cnt+1 (8-bit) and go to READ.
- In IDLE: cpu_rdy_out=1, dma_active_out=0, mem_r_nw_out=1, mem_a_out=0, mem_d_out=0.
- Parity tracker: a 1-bit register toggles on every cpu_cyc_in, including during reset release. Its value 1 means an odd CPU cycle.
- Writes to 0x4014 seen outside IDLE are ignored. The page is fixed for the whole transfer.
- Reads of 0x4014 have no effect.

## Timing
- Reset (rst_n_in=0 at a clk_in edge) forces IDLE outputs, cnt=0, page=0, data=0, parity=0, and dma_done_out=0. A reset mid-transfer aborts immediately and does not pulse dma_done_out.
- All outputs are registered and change only on clk_in edges. State advances only on clk_in edges where cpu_cyc_in=1.
- Duration from the triggering cpu_cyc_in to cpu_rdy_out returning high is 513 CPU cycles without alignment and 514 CPU cycles with alignment.
- dma_done_out and cpu_rdy_out=1 and dma_active_out=0 all assert on the same clk_in edge.
- cnt wraps from 0xFF only at termination, so exactly 256 writes are issued per transfer.

## Configuration
- SPR_DMA_ODD_ALIGN_EN:
  - Defined: HALT goes to ALIGN when parity=1 at the HALT exit edge, giving 514 cycles; otherwise it goes to READ, giving 513 cycles. This matches hardware get/put alignment.
  - Undefined: ALIGN is never entered, every transfer takes exactly 513 cycles, and the parity register is removed.

## Test plan
- Write 0x02 to 0x4014 with memory 0x0200+i = i^8'hA5 -> 256 writes to 0x2004 carrying i^8'hA5 in order, one dma_done_out pulse, then cpu_rdy_out=1.
- Trigger on an even cycle and on an odd cycle with SPR_DMA_ODD_ALIGN_EN defined -> 513 and 514 CPU cycles respectively. With the macro undefined -> 513 for both.
- Hold cpu_cyc_in low for 10 clk_in mid-transfer -> no state, address, or cnt change, and the transfer resumes intact.
- A write to 0x4014 during WRITE of cnt=0x40 -> ignored, and page and cnt are unchanged.
- Assert rst_n_in=0 at cnt=0x80 -> the next edge gives cpu_rdy_out=1, dma_active_out=0, mem_a_out=0, and no dma_done_out. A new 0x4014 write restarts from cnt=0.
- A page 0xFF source -> reads addresses 0xFF00..0xFFFF with no address overflow into page 0x00.
